// File: rtl/des_key_schedule.sv
// DES subkey generator: PC-1, per-round C/D rotation and PC-2, with a valid/ready subkey stream.
// Define KEY_PARITY_CHECK_EN to flag keys that contain an even-parity byte.
module des_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter logic [15:0] SHIFT_MAP  = 16'h8103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [64:1] Key_In,
  input  logic        Key_Valid,
  output logic        Key_Ready,
  input  logic        Decrypt,
  output logic [48:1] Subkey,
  output logic [3:0]  Subkey_Round,
  output logic        Subkey_Valid,
  input  logic        Subkey_Ready,
  output logic        Schedule_Done,
  output logic        Parity_Error
);

  localparam int Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic int unsigned total_shift();
    int unsigned s;
    s = 0;
    for (int r = 0; r < int'(NUM_ROUNDS); r++) s += SHIFT_MAP[r] ? 1 : 2;
    return s % 28;
  endfunction

  localparam int unsigned TotalShift = total_shift();
  localparam logic [3:0]  LastIdx    = 4'(NUM_ROUNDS - 1);

  // cd[55] holds C bit 1, cd[27] holds D bit 1; rotate-left moves bits toward the MSB.
  function automatic logic [27:0] rotl28(logic [27:0] x, int unsigned s);
    logic [55:0] t;
    t = {x, x} << s;
    return t[55:28];
  endfunction

  function automatic logic [55:0] rotl_cd(logic [55:0] cd, int unsigned s);
    return {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
  endfunction

  function automatic logic [55:0] pc1(logic [64:1] key);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = key[65-Pc1[i]];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-Pc2[i]];
    return k;
  endfunction

  typedef enum logic [1:0] {StIdle, StLoad, StGen} state_e;

  state_e      state_q;
  logic [55:0] cd_q;
  logic        dec_q;
  logic [47:0] sk_q;
  logic [3:0]  round_q;
  logic        valid_q;
  logic        done_q;

  logic [3:0]  emit_idx;
  logic [3:0]  sel;
  int unsigned amt;
  logic [55:0] cd_fwd;
  logic [55:0] cd_rev;

  // Shift for the round being emitted: round e+1 when encrypting, round N-e when decrypting.
  always_comb begin
    emit_idx = valid_q ? round_q + 4'd1 : 4'd0;
    sel      = dec_q ? LastIdx - emit_idx : emit_idx;
    amt      = SHIFT_MAP[sel] ? 1 : 2;
    cd_fwd   = rotl_cd(cd_q, amt);
    cd_rev   = rotl_cd(cd_q, 28 - amt);
  end

`ifdef KEY_PARITY_CHECK_EN
  logic perr_q;

  function automatic logic parity_bad(logic [64:1] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad |= ~(^key[8*b+1 +: 8]);
    return bad;
  endfunction

  assign Parity_Error = perr_q;
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{Key_In[57], Key_In[49], Key_In[41], Key_In[33],
                                Key_In[25], Key_In[17], Key_In[9], Key_In[1]};
  assign Parity_Error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      sk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Key_Valid) begin
            cd_q    <= pc1(Key_In);
            dec_q   <= Decrypt;
            state_q <= StLoad;
`ifdef KEY_PARITY_CHECK_EN
            perr_q  <= parity_bad(Key_In);
`endif
          end
        end
        StLoad: begin
          if (dec_q) cd_q <= rotl_cd(cd_q, TotalShift);
          state_q <= StGen;
        end
        StGen: begin
          if (!valid_q || Subkey_Ready) begin
            if (valid_q && round_q == LastIdx) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              valid_q <= 1'b1;
              round_q <= emit_idx;
              if (dec_q) begin
                sk_q <= pc2(cd_q);
                cd_q <= cd_rev;
              end else begin
                sk_q <= pc2(cd_fwd);
                cd_q <= cd_fwd;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Key_Ready     = (state_q == StIdle);
  assign Subkey        = sk_q;
  assign Subkey_Round  = round_q;
  assign Subkey_Valid  = valid_q;
  assign Schedule_Done = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a bit-level DES key-schedule model fills an expected
// queue; a monitor pops and compares on every subkey handshake.
module tb_des_key_schedule;

  localparam int          NR   = 16;
  localparam logic [15:0] SMAP = 16'h8103;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic        clk;
  logic        rst;
  logic [64:1] Key_In;
  logic        Key_Valid;
  logic        Key_Ready;
  logic        Decrypt;
  logic [48:1] Subkey;
  logic [3:0]  Subkey_Round;
  logic        Subkey_Valid;
  logic        Subkey_Ready;
  logic        Schedule_Done;
  logic        Parity_Error;

  des_key_schedule #(
    .NUM_ROUNDS (NR),
    .SHIFT_MAP  (SMAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Key_In        (Key_In),
    .Key_Valid     (Key_Valid),
    .Key_Ready     (Key_Ready),
    .Decrypt       (Decrypt),
    .Subkey        (Subkey),
    .Subkey_Round  (Subkey_Round),
    .Subkey_Valid  (Subkey_Valid),
    .Subkey_Ready  (Subkey_Ready),
    .Schedule_Done (Schedule_Done),
    .Parity_Error  (Parity_Error)
  );

  typedef struct packed {
    logic [3:0]  round;
    logic [47:0] sk;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          stall_round = 0;
  int          stall_left = 0;
  logic [47:0] first_sk;
  logic [47:0] last_sk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s got=%h required=%h", name, got, req);
  endtask

  // Subkey for DES round r: C_r/D_r are C0/D0 rotated left by the cumulative shift.
  function automatic logic [47:0] model_subkey(logic [63:0] key, int r);
    int          cum;
    bit          cd [56];
    logic [47:0] k;
    cum = 0;
    for (int q = 1; q <= r; q++) cum += SMAP[q-1] ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      cd[i]    = key[64 - PC1[(i + cum) % 28]];
      cd[28+i] = key[64 - PC1[28 + (i + cum) % 28]];
    end
    for (int j = 0; j < 48; j++) k[47-j] = cd[PC2[j] - 1];
    return k;
  endfunction

  function automatic logic model_perr(logic [63:0] key);
`ifdef KEY_PARITY_CHECK_EN
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Backpressure: hold Subkey_Ready low for stall_left cycles once stall_round is shown.
  initial Subkey_Ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (Subkey_Valid && int'(Subkey_Round) == stall_round && stall_left > 0) begin
      Subkey_Ready = 1'b0;
      stall_left--;
    end else begin
      Subkey_Ready = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && Subkey_Valid && Subkey_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_subkey got=%h round=%0d required=none", Subkey, Subkey_Round);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("subkey_e%0d", e.round), 64'(Subkey), 64'(e.sk));
        check($sformatf("round_e%0d", e.round), 64'(Subkey_Round), 64'(e.round));
        if (e.round == 4'd0) first_sk = Subkey;
        if (e.round == 4'(NR - 1)) last_sk = Subkey;
      end
    end
  end

  task automatic push_expected(input logic [63:0] key, input bit dec);
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      e.round = 4'(i);
      e.sk    = model_subkey(key, dec ? NR - i : i + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic accept_key(input logic [63:0] key, input bit dec);
    check("key_ready_idle", 64'(Key_Ready), 64'd1);
    Key_In    = key;
    Decrypt   = dec;
    Key_Valid = 1'b1;
    @(posedge clk);
    #1;
    Key_Valid = 1'b0;
    check("parity_error", 64'(Parity_Error), 64'(model_perr(key)));
  endtask

  task automatic run_key(input logic [63:0] key, input bit dec, input int st_round,
                         input int st_len, input bit inject, input bit do_kat,
                         input logic [47:0] kat_first, input logic [47:0] kat_last);
    int cyc;
    bit seen;
    push_expected(key, dec);
    stall_round = st_round;
    stall_left  = st_len;
    accept_key(key, dec);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (Schedule_Done) begin
        seen = 1'b1;
      end else begin
        if (inject && cyc == 3) begin
          Key_In    = ~key;
          Decrypt   = ~dec;
          Key_Valid = 1'b1;
        end
        if (inject && cyc == 10) Key_Valid = 1'b0;
        if (cyc == 5) check("key_ready_busy", 64'(Key_Ready), 64'd0);
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout got=no_done_after_%0d_cycles required=done", cyc);
    end else begin
      check("done_cycle", 64'(cyc), 64'(18 + st_len));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("valid_after_done", 64'(Subkey_Valid), 64'd0);
      check("ready_after_done", 64'(Key_Ready), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'(Schedule_Done), 64'd0);
    end
    if (do_kat) begin
      check("kat_first", 64'(first_sk), 64'(kat_first));
      check("kat_last", 64'(last_sk), 64'(kat_last));
    end
    exp_q.delete();
  endtask

  task automatic reset_mid(input logic [63:0] key);
    int  n;
    int  dones;
    push_expected(key, 1'b0);
    stall_left = 0;
    accept_key(key, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(Subkey_Valid && Subkey_Round == 4'd7) && n < 40);
    check("reached_round7", 64'(Subkey_Round), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(Subkey_Valid), 64'd0);
    check("rst_key_ready", 64'(Key_Ready), 64'd1);
    check("rst_subkey", 64'(Subkey), 64'd0);
    exp_q.delete();
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Schedule_Done) dones++;
    end
    check("no_done_after_rst", 64'(dones), 64'd0);
  endtask

  localparam logic [63:0] KatKey = 64'h1334_5779_9BBC_DFF1;
  localparam logic [47:0] KatK1  = 48'h1B02_EFFC_7072;
  localparam logic [47:0] KatK16 = 48'hCB3D_8B0E_17F5;

  initial begin
    logic [63:0] rk;
    rst       = 1'b1;
    Key_Valid = 1'b0;
    Key_In    = '0;
    Decrypt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_key_ready", 64'(Key_Ready), 64'd1);
    check("reset_valid", 64'(Subkey_Valid), 64'd0);
    check("reset_done", 64'(Schedule_Done), 64'd0);
    check("reset_parity", 64'(Parity_Error), 64'd0);
    check("reset_subkey", 64'(Subkey), 64'd0);
    check("reset_round", 64'(Subkey_Round), 64'd0);

    run_key(KatKey, 1'b0, 0, 0, 1'b0, 1'b1, KatK1, KatK16);
    run_key(KatKey, 1'b1, 0, 0, 1'b0, 1'b1, KatK16, KatK1);
    run_key(64'h1334_5779_9BBC_DFF0, 1'b0, 0, 0, 1'b0, 1'b0, '0, '0);
    run_key({$urandom, $urandom}, 1'b0, 3, 5, 1'b0, 1'b0, '0, '0);
    run_key({$urandom, $urandom}, 1'b1, 0, 0, 1'b1, 1'b0, '0, '0);
    reset_mid({$urandom, $urandom});
    run_key(KatKey, 1'b0, 0, 0, 1'b0, 1'b1, KatK1, KatK16);
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom};
      run_key(rk, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
